// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver block.
//   PAR_NONE/PAR_ODD/PAR_EVEN : cfg_parity encodings (3 is reserved and decodes as none)
//   MIN_DIV                   : smallest clocks-per-bit the receiver will use
//   rx_state_e                : receiver FSM states
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int unsigned MIN_DIV = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StPush
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : write request and data; must only be asserted when !full or rd_en
//   rd_en           : pop the head entry; ignored when empty
//   rd_data         : head entry (undefined contents while empty)
//   full, empty     : occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same index, opposite wrap bit: writer is one full lap ahead.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_rd = rd_en && !empty;

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // When full with a simultaneous pop, this overwrites the slot being vacated.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, start-bit glitch rejection,
// per-character error flags and an output FIFO drained through valid/ready.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   rx                 : asynchronous serial input, idles high
//   cfg_div            : clocks per bit (values below MIN_DIV use MIN_DIV)
//   cfg_parity         : 0 none, 1 odd, 2 even, 3 none
//   cfg_stop2          : check two stop bits
//   out_valid/out_ready: output stream handshake, pop on valid && ready
//   out_data           : head character
//   out_frame_err      : head character had a stop bit sampled low
//   out_parity_err     : head character failed the parity check
//   overflow           : sticky, a character was dropped on a full FIFO
//   clr_overflow       : clears overflow (a simultaneous set wins)
//   busy               : receiver is inside a frame
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_frame_err,
    output logic                 out_parity_err,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned  EW       = DATA_BITS + 2;
    localparam logic [3:0]   LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    rx_state_e              state_q, state_d;
    logic                   rx_meta_q, rx_s_q, rx_d_q;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [1:0]             par_q, par_d;
    logic                   stop2_q, stop2_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    logic                   fall, sample, par_en, par_xor, push;
    logic                   fifo_full, fifo_empty, fifo_wr, pop;
    logic [EW-1:0]          fifo_rd_data;

    assign fall    = rx_d_q && !rx_s_q;
    assign par_en  = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    assign par_xor = (^shift_q) ^ rx_s_q;

    always_comb begin
        sample = 1'b0;
        if (state_q == StStart) begin
            sample = (cnt_q == (div_q >> 1) - DIV_ONE);
        end else if (state_q == StData || state_q == StParity || state_q == StStop) begin
            sample = (cnt_q == div_q - DIV_ONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + DIV_ONE;
        div_d       = div_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d     = StStart;
                    div_d       = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
                    par_d       = cfg_parity;
                    stop2_d     = cfg_stop2;
                    bit_cnt_d   = '0;
                    stop_cnt_d  = 1'b0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            StStart: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (sample) state_d = rx_s_q ? StIdle : StData;
            end
            StData: begin
                if (sample) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = par_en ? StParity : StStop;
                end
            end
            StParity: begin
                if (sample) begin
                    par_err_d = (par_q == PAR_ODD) ? !par_xor : par_xor;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (sample) begin
                    frame_err_d = frame_err_q | !rx_s_q;
                    if (!stop2_q || stop_cnt_q) state_d = StPush;
                    else stop_cnt_d = 1'b1;
                end
            end
            StPush: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle || sample || state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            cnt_q       <= '0;
            div_q       <= DIV_MIN;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_d_q      <= rx_s_q;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // A full FIFO still accepts the write if the head leaves in the same cycle.
    assign pop        = out_valid && out_ready;
    assign fifo_wr    = push && (!fifo_full || pop);
    assign overflow_d = (push && fifo_full && !pop) ? 1'b1 :
                        (clr_overflow ? 1'b0 : overflow_q);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data ({par_err_q, frame_err_q, shift_q}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs read as zero while empty so stale storage never shows.
    assign out_valid      = !fifo_empty;
    assign out_data       = fifo_empty ? '0 : fifo_rd_data[DATA_BITS-1:0];
    assign out_frame_err  = !fifo_empty && fifo_rd_data[DATA_BITS];
    assign out_parity_err = !fifo_empty && fifo_rd_data[DATA_BITS+1];
    assign overflow       = overflow_q;
    assign busy           = (state_q != StIdle);

endmodule
